alu_exec_unit: RTL and testbench

- Parametrised execute stage for the MiniAlu-class processor. It takes one decoded instruction with its RAM operands and produces registered RAM write, branch and LED strobes.
- Compared with the current combinational ALU it adds:
  - a multi-cycle signed/unsigned shift-add multiplier with a full-width hi/lo writeback;
  - a valid/ready handshake, so the instruction fetch stage stalls while the multiplier is busy.

---
 rtl/alu_exec_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage of the MiniAlu-class core.
// Single-cycle ALU/branch/LED ops plus a multi-cycle shift-add multiplier
// with a full-width hi/lo writeback and a valid/ready handshake to fetch.
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, multiplies start here
// MUL   | one shift-add step per cycle, down-counter from DATA_WIDTH
// DONE  | lo/hi writeback strobes are on the outputs for this cycle
module alu_exec_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int HI_ADDR        = 9,
  parameter bit SIGNED_COMPARE = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [3:0]            iOperation,
  input  logic [DATA_WIDTH-1:0] iSourceData0,
  input  logic [DATA_WIDTH-1:0] iSourceData1,
  input  logic [15:0]           iImmediate,
  input  logic [ADDR_WIDTH-1:0] iDestination,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oMulHiEnable,
  output logic [DATA_WIDTH-1:0] oResultHi,
  output logic                  oBranchTaken,
  output logic [ADDR_WIDTH-1:0] oBranchTarget,
  output logic                  oLedEnable,
  output logic [7:0]            oLedData
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_STO  = 4'd3;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_LED  = 4'd6;
  localparam logic [3:0] OP_SMUL = 4'd7;
  localparam logic [3:0] OP_UMUL = 4'd8;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = 2 * DATA_WIDTH;

  // The high half is written to a fixed RAM address, so it must exist.
  if (DATA_WIDTH < 4) begin : gBadWidth
    $error("alu_exec_unit: DATA_WIDTH must be at least 4");
  end
  if (HI_ADDR < 0 || HI_ADDR >= (1 << ADDR_WIDTH)) begin : gBadHiAddr
    $error("alu_exec_unit: HI_ADDR does not fit in ADDR_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} stateT;

  stateT                 state;
  logic [PW-1:0]         accum;
  logic [PW-1:0]         multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic                  negate;
  logic [ADDR_WIDTH-1:0] mulDest;
  logic [CW-1:0]         count;

  logic                  isSmul;
  logic [DATA_WIDTH-1:0] mag0;
  logic [DATA_WIDTH-1:0] mag1;
  logic                  bleTaken;
  logic [PW-1:0]         accumNext;
  logic [PW-1:0]         productFinal;

  // Operand magnitudes, branch compare and the next multiplier step
  always_comb begin
    isSmul = (iOperation == OP_SMUL);
    // The most-negative value maps onto itself, which read unsigned is
    // exactly its magnitude, so no extra bit is needed.
    mag0 = (isSmul && iSourceData0[DATA_WIDTH-1]) ? -iSourceData0 : iSourceData0;
    mag1 = (isSmul && iSourceData1[DATA_WIDTH-1]) ? -iSourceData1 : iSourceData1;
    if (SIGNED_COMPARE) bleTaken = ($signed(iSourceData1) <= $signed(iSourceData0));
    else                bleTaken = (iSourceData1 <= iSourceData0);
    accumNext    = accum + (multiplier[0] ? multiplicand : '0);
    productFinal = negate ? -accumNext : accumNext;
  end

  // Execute FSM with registered strobes and data
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      oReady        <= 1'b1;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oResult       <= '0;
      oMulHiEnable  <= 1'b0;
      oResultHi     <= '0;
      oBranchTaken  <= 1'b0;
      oBranchTarget <= '0;
      oLedEnable    <= 1'b0;
      oLedData      <= '0;
      accum         <= '0;
      multiplicand  <= '0;
      multiplier    <= '0;
      negate        <= 1'b0;
      mulDest       <= '0;
      count         <= '0;
    end else begin
      oWriteEnable <= 1'b0;
      oMulHiEnable <= 1'b0;
      oBranchTaken <= 1'b0;
      oLedEnable   <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            case (iOperation)
              OP_ADD: begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= iDestination;
                oResult       <= iSourceData1 + iSourceData0;
              end
              OP_SUB: begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= iDestination;
                oResult       <= iSourceData1 - iSourceData0;
              end
              OP_STO: begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= iDestination;
                oResult       <= DATA_WIDTH'(iImmediate);
              end
              OP_BLE: begin
                oBranchTaken  <= bleTaken;
                oBranchTarget <= iDestination;
              end
              OP_JMP: begin
                oBranchTaken  <= 1'b1;
                oBranchTarget <= iDestination;
              end
              OP_LED: begin
                oLedEnable <= 1'b1;
                oLedData   <= 8'(iSourceData1);
              end
              OP_SMUL, OP_UMUL: begin
                multiplicand <= PW'(mag1);
                multiplier   <= mag0;
                accum        <= '0;
                negate       <= isSmul &&
                                (iSourceData1[DATA_WIDTH-1] ^ iSourceData0[DATA_WIDTH-1]);
                mulDest      <= iDestination;
                count        <= CW'(DATA_WIDTH);
                state        <= MUL;
                oReady       <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          accum        <= accumNext;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          count        <= count - 1'b1;
          // Last step: the finished product goes straight to the outputs,
          // so the strobes are visible for the whole DONE cycle.
          if (count == CW'(1)) begin
            state         <= DONE;
            oWriteEnable  <= 1'b1;
            oWriteAddress <= mulDest;
            oResult       <= productFinal[DATA_WIDTH-1:0];
            oMulHiEnable  <= 1'b1;
            oResultHi     <= productFinal[PW-1:DATA_WIDTH];
          end
        end
        DONE: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors against three configurations
// (16-bit unsigned BLE, 16-bit signed BLE, 8-bit) with a behavioural model
// compared every cycle and literal expectations at key points.
module tb_alu_exec_unit;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, STO = 4'd3, BLE = 4'd4,
                         JMP = 4'd5, LED = 4'd6, SMUL = 4'd7, UMUL = 4'd8;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // bus 0 drives instances A and B, bus 1 drives instance C
  logic        rst0, b0Valid, rst1, b1Valid;
  logic [3:0]  b0Op, b1Op;
  logic [15:0] b0Src0, b0Src1, b0Imm, b1Src0, b1Src1, b1Imm;
  logic [7:0]  b0Dest, b1Dest;

  logic rdyA, weA, hiEnA, brA, ledA; logic [7:0] addrA, tgtA, ledDA; logic [15:0] resA, hiA;
  logic rdyB, weB, hiEnB, brB, ledB; logic [7:0] addrB, tgtB, ledDB; logic [15:0] resB, hiB;
  logic rdyC, weC, hiEnC, brC, ledC; logic [7:0] addrC, tgtC, ledDC; logic [7:0]  resC, hiC;

  alu_exec_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .HI_ADDR(9), .SIGNED_COMPARE(1'b0)) dutA (
    .Clock(Clock), .Reset(rst0), .iValid(b0Valid), .oReady(rdyA), .iOperation(b0Op),
    .iSourceData0(b0Src0), .iSourceData1(b0Src1), .iImmediate(b0Imm), .iDestination(b0Dest),
    .oWriteEnable(weA), .oWriteAddress(addrA), .oResult(resA), .oMulHiEnable(hiEnA),
    .oResultHi(hiA), .oBranchTaken(brA), .oBranchTarget(tgtA), .oLedEnable(ledA), .oLedData(ledDA));

  alu_exec_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .HI_ADDR(9), .SIGNED_COMPARE(1'b1)) dutB (
    .Clock(Clock), .Reset(rst0), .iValid(b0Valid), .oReady(rdyB), .iOperation(b0Op),
    .iSourceData0(b0Src0), .iSourceData1(b0Src1), .iImmediate(b0Imm), .iDestination(b0Dest),
    .oWriteEnable(weB), .oWriteAddress(addrB), .oResult(resB), .oMulHiEnable(hiEnB),
    .oResultHi(hiB), .oBranchTaken(brB), .oBranchTarget(tgtB), .oLedEnable(ledB), .oLedData(ledDB));

  alu_exec_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .HI_ADDR(9), .SIGNED_COMPARE(1'b0)) dutC (
    .Clock(Clock), .Reset(rst1), .iValid(b1Valid), .oReady(rdyC), .iOperation(b1Op),
    .iSourceData0(b1Src0[7:0]), .iSourceData1(b1Src1[7:0]), .iImmediate(b1Imm), .iDestination(b1Dest),
    .oWriteEnable(weC), .oWriteAddress(addrC), .oResult(resC), .oMulHiEnable(hiEnC),
    .oResultHi(hiC), .oBranchTaken(brC), .oBranchTarget(tgtC), .oLedEnable(ledC), .oLedData(ledDC));

  // ---------------- behavioural model ----------------
  logic        eReady[3], eWe[3], eHiEn[3], eBr[3], eLed[3], eChkAll[3];
  logic [7:0]  eAddr[3], eTgt[3], eLedD[3], pDest[3];
  logic [15:0] eRes[3], eHi[3], pLo[3], pHi[3];
  int          phase[3], remain[3];   // phase: 0 idle, 1 multiplying, 2 writeback

  function automatic int wOf(input int id);
    return (id == 2) ? 8 : 16;
  endfunction

  task automatic modelStep(input int id, input logic rst, input logic v, input logic [3:0] o,
                           input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] im,
                           input logic [7:0] d);
    int w;
    longint mask, x0, x1, sx0, sx1, p;
    w    = wOf(id);
    mask = (longint'(1) << w) - 1;
    x0   = longint'(a0) & mask;
    x1   = longint'(a1) & mask;
    sx0  = x0[w-1] ? x0 - (longint'(1) << w) : x0;
    sx1  = x1[w-1] ? x1 - (longint'(1) << w) : x1;
    eWe[id] = 0; eHiEn[id] = 0; eBr[id] = 0; eLed[id] = 0; eChkAll[id] = 0;
    if (rst) begin
      phase[id] = 0; eReady[id] = 1; eChkAll[id] = 1;
      eAddr[id] = 0; eRes[id] = 0; eHi[id] = 0; eTgt[id] = 0; eLedD[id] = 0;
    end else begin
      case (phase[id])
        0: if (v) begin
          case (o)
            ADD: begin eWe[id] = 1; eAddr[id] = d; eRes[id] = 16'((x1 + x0) & mask); end
            SUB: begin eWe[id] = 1; eAddr[id] = d; eRes[id] = 16'((x1 - x0) & mask); end
            STO: begin eWe[id] = 1; eAddr[id] = d; eRes[id] = 16'(longint'(im) & mask); end
            BLE: begin eBr[id] = (id == 1) ? (sx1 <= sx0) : (x1 <= x0); eTgt[id] = d; end
            JMP: begin eBr[id] = 1; eTgt[id] = d; end
            LED: begin eLed[id] = 1; eLedD[id] = 8'(x1); end
            SMUL, UMUL: begin
              p = (o == SMUL) ? sx1 * sx0 : x1 * x0;
              pLo[id] = 16'(p & mask);
              pHi[id] = 16'((p >>> w) & mask);
              pDest[id] = d; phase[id] = 1; remain[id] = w; eReady[id] = 0;
            end
            default: ;
          endcase
        end
        1: begin
          remain[id]--;
          if (remain[id] == 0) begin
            phase[id] = 2; eWe[id] = 1; eAddr[id] = pDest[id]; eRes[id] = pLo[id];
            eHiEn[id] = 1; eHi[id] = pHi[id];
          end
        end
        default: begin phase[id] = 0; eReady[id] = 1; end
      endcase
    end
  endtask

  // Advance the model on every active edge using the inputs the DUTs sampled
  always @(posedge Clock) begin
    modelStep(0, rst0, b0Valid, b0Op, b0Src0, b0Src1, b0Imm, b0Dest);
    modelStep(1, rst0, b0Valid, b0Op, b0Src0, b0Src1, b0Imm, b0Dest);
    modelStep(2, rst1, b1Valid, b1Op, b1Src0, b1Src1, b1Imm, b1Dest);
    started = 1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInst(input int id, input logic rdy, input logic we, input logic [7:0] addr,
                           input logic [15:0] res, input logic hiEn, input logic [15:0] hi,
                           input logic br, input logic [7:0] tgt, input logic led,
                           input logic [7:0] ledD);
    string n;
    n = $sformatf("model%0d", id);
    chk({n, ".ready"}, rdy, eReady[id]);
    chk({n, ".writeEnable"}, we, eWe[id]);
    chk({n, ".mulHiEnable"}, hiEn, eHiEn[id]);
    chk({n, ".branchTaken"}, br, eBr[id]);
    chk({n, ".ledEnable"}, led, eLed[id]);
    if (eWe[id] || eChkAll[id]) begin
      chk({n, ".writeAddress"}, addr, eAddr[id]);
      chk({n, ".result"}, res, eRes[id]);
    end
    if (eHiEn[id] || eChkAll[id]) chk({n, ".resultHi"}, hi, eHi[id]);
    if (eBr[id] || eChkAll[id])   chk({n, ".branchTarget"}, tgt, eTgt[id]);
    if (eLed[id] || eChkAll[id])  chk({n, ".ledData"}, ledD, eLedD[id]);
  endtask

  // Compare every DUT against the model, away from the active edge
  always @(negedge Clock) begin
    if (started) begin
      checkInst(0, rdyA, weA, addrA, resA, hiEnA, hiA, brA, tgtA, ledA, ledDA);
      checkInst(1, rdyB, weB, addrB, resB, hiEnB, hiB, brB, tgtB, ledB, ledDB);
      checkInst(2, rdyC, weC, addrC, {8'h00, resC}, hiEnC, {8'h00, hiC}, brC, tgtC, ledC, ledDC);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue0(input logic [3:0] o, input logic [15:0] s1, input logic [15:0] s0,
                        input logic [7:0] d);
    b0Valid = 1; b0Op = o; b0Src1 = s1; b0Src0 = s0; b0Dest = d;
  endtask

  task automatic issue1(input logic [3:0] o, input logic [15:0] s1, input logic [15:0] s0,
                        input logic [7:0] d);
    b1Valid = 1; b1Op = o; b1Src1 = s1; b1Src0 = s0; b1Dest = d;
  endtask

  task automatic drop0(); b0Valid = 0; b0Op = NOP; endtask
  task automatic drop1(); b1Valid = 0; b1Op = NOP; endtask

  // Issue a multiply on bus 0, wait (bounded) for its writeback and check it
  task automatic runMul0(input string name, input logic [3:0] o, input logic [15:0] s1,
                         input logic [15:0] s0, input logic [15:0] lo, input logic [15:0] hi);
    bit found;
    issue0(o, s1, s0, 8'd12);
    tick(); drop0();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (hiEnA) found = 1;
      else tick();
    end
    chk({name, ".writebackSeen"}, found, 1);
    chk({name, ".lo"}, resA, lo);
    chk({name, ".hi"}, hiA, hi);
    tick();
  endtask

  initial begin
    int weCount, hits, mulW;
    bit accepted;
    rst0 = 1; rst1 = 1; b0Valid = 0; b1Valid = 0; b0Op = NOP; b1Op = NOP;
    b0Src0 = 0; b0Src1 = 0; b0Imm = 0; b0Dest = 0;
    b1Src0 = 0; b1Src1 = 0; b1Imm = 0; b1Dest = 0;
    tick(); tick();
    chk("reset.ready", rdyA, 1);
    chk("reset.writeEnable", weA, 0);
    chk("reset.result", resA, 0);
    chk("reset.readyC", rdyC, 1);
    rst0 = 0; rst1 = 0;

    // ADD with carry out of the sign bit
    issue0(ADD, 16'h7FFF, 16'h0001, 8'd3);
    tick(); drop0();
    chk("add.writeEnable", weA, 1);
    chk("add.address", addrA, 8'd3);
    chk("add.result", resA, 16'h8000);
    tick();
    chk("add.strobeOneCycle", weA, 0);

    // BLE: 5 <= 0xFFFF unsigned, but 5 > -1 signed
    issue0(BLE, 16'h0005, 16'hFFFF, 8'd7);
    tick(); drop0();
    chk("ble.unsignedTaken", brA, 1);
    chk("ble.target", tgtA, 8'd7);
    chk("ble.signedNotTaken", brB, 0);
    chk("ble.noWrite", weA, 0);

    issue0(SUB, 16'h0003, 16'h0005, 8'd2);
    tick(); drop0();
    chk("sub.result", resA, 16'hFFFE);

    b0Imm = 16'hABCD;
    issue0(STO, 16'h0, 16'h0, 8'd5);
    tick(); drop0();
    chk("sto.result", resA, 16'hABCD);

    issue0(JMP, 16'h0, 16'h0, 8'h20);
    tick(); drop0();
    chk("jmp.taken", brA, 1);
    chk("jmp.target", tgtA, 8'h20);

    issue0(LED, 16'h12A5, 16'h0, 8'd0);
    tick(); drop0();
    chk("led.enable", ledA, 1);
    chk("led.data", ledDA, 8'hA5);

    // back-to-back single-cycle ops, then an undefined code
    issue0(ADD, 16'd10, 16'd20, 8'd10); tick();
    issue0(SUB, 16'd10, 16'd20, 8'd11); tick();
    chk("backToBack.result", resA, 16'hFFF6);
    issue0(4'hF, 16'd1, 16'd1, 8'd1); tick(); drop0();
    chk("undefined.noWrite", weA, 0);

    // SMUL -3 x 5: busy for cycles 1-17, writeback in cycle 17
    issue0(SMUL, 16'hFFFD, 16'h0005, 8'd4);
    tick(); drop0();
    b0Src0 = 16'h1234; b0Src1 = 16'h5678;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 17) chk("smul.busy", rdyA, 0);
      else         chk("smul.readyAgain", rdyA, 1);
      if (c == 17) begin
        chk("smul.writeEnable", weA, 1);
        chk("smul.address", addrA, 8'd4);
        chk("smul.lo", resA, 16'hFFF1);
        chk("smul.hiEnable", hiEnA, 1);
        chk("smul.hi", hiA, 16'hFFFF);
      end else chk("smul.noEarlyWrite", weA, 0);
      if (c < 18) tick();
    end

    runMul0("smulMostNeg", SMUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000);
    runMul0("umulMax", UMUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
    runMul0("smulPosNeg", SMUL, 16'h0007, 16'hFFFE, 16'hFFF2, 16'hFFFF);

    // reset in the middle of a multiply aborts it
    issue0(SMUL, 16'd7, 16'd9, 8'd6);
    tick(); drop0();
    tick(); tick(); tick(); tick();
    rst0 = 1;
    tick();
    rst0 = 0;
    chk("abort.ready", rdyA, 1);
    chk("abort.writeEnable", weA, 0);
    chk("abort.hiEnable", hiEnA, 0);
    chk("abort.result", resA, 0);
    chk("abort.resultHi", hiA, 0);
    weCount = 0;
    for (int i = 0; i < 25; i++) begin
      if (weA || hiEnA) weCount++;
      tick();
    end
    chk("abort.noWriteback", weCount, 0);
    issue0(ADD, 16'd2, 16'd2, 8'd1);
    tick(); drop0();
    chk("abort.addAfter", resA, 16'd4);

    // ADD held with iValid during a multiply executes exactly once
    issue0(UMUL, 16'd3, 16'd4, 8'd8);
    tick();
    b0Op = ADD; b0Src1 = 16'd1; b0Src0 = 16'd2; b0Dest = 8'd9;
    hits = 0; mulW = 0; accepted = 0;
    for (int i = 0; i < 40; i++) begin
      if (weA && addrA == 8'd9) begin hits++; chk("held.result", resA, 16'd3); end
      if (weA && addrA == 8'd8) mulW++;
      if (rdyA && !accepted) begin accepted = 1; tick(); drop0(); end
      else tick();
    end
    chk("held.accepted", accepted, 1);
    chk("held.singleWrite", hits, 1);
    chk("held.mulWrite", mulW, 1);

    // 8-bit instance: SMUL -128 x 127 writes back in cycle 9
    issue1(SMUL, 16'h0080, 16'h007F, 8'd4);
    tick(); drop1();
    for (int c = 1; c <= 10; c++) begin
      if (c <= 9) chk("w8.busy", rdyC, 0);
      else        chk("w8.readyAgain", rdyC, 1);
      if (c == 9) begin
        chk("w8.writeEnable", weC, 1);
        chk("w8.lo", resC, 8'h80);
        chk("w8.hiEnable", hiEnC, 1);
        chk("w8.hi", hiC, 8'hC0);
      end else chk("w8.noEarlyWrite", weC, 0);
      if (c < 10) tick();
    end
    issue1(ADD, 16'h00F0, 16'h0020, 8'd2);
    tick(); drop1();
    chk("w8.addWrap", resC, 8'h10);
    b1Imm = 16'h1234;
    issue1(STO, 16'h0, 16'h0, 8'd3);
    tick(); drop1();
    chk("w8.stoTruncate", resC, 8'h34);
    issue1(UMUL, 16'h00FF, 16'h00FF, 8'd5);
    tick(); drop1();
    for (int i = 0; i < 12; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
